// File: rtl/xor_mon_pkg.sv
// xor_mon_pkg: shared state type, default timing and parity helper for the XOR fault monitor.
package xor_mon_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SETTLE_DEF = 8;
  localparam int SAMPLE_IDX = SYNC_STAGES_DEF + SETTLE_DEF;
  function automatic logic parity5(input logic [4:0] a);
    return ^a;
  endfunction
endpackage

// File: rtl/xor_fault_monitor_sync_chain.sv
// sync_chain: STAGES-deep flop synchroniser for a single asynchronous input, reset to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s_q, s_d;
  always_comb s_d = {s_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) s_q <= '0;
    else s_q <= s_d;
  assign q = s_q[STAGES-1];
endmodule

// File: rtl/xor_fault_monitor.sv
// xor_fault_monitor: drives probe/pattern into the XOR gate, samples its output once per
// half-period and logs mismatches with a saturating count, sticky flag and first-fault timestamp.
module xor_fault_monitor
  import xor_mon_pkg::*;
#(
  parameter int HALF_PERIOD = 64,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int SETTLE      = SAMPLE_IDX - SYNC_STAGES_DEF,
  parameter int CNT_W       = 16,
  parameter int TS_W        = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             clear,
  input  logic [4:0]       a_in,
  input  logic             q_in,
  output logic [4:0]       a_out,
  output logic             probe,
  output logic             active,
  output logic             sample_valid,
  output logic             fault_pulse,
  output logic             fault_sticky,
  output logic [CNT_W-1:0] fault_count,
  output logic [TS_W-1:0]  first_fault_time
);
  localparam int PW = $clog2(HALF_PERIOD);
  localparam int SIDX = SYNC_STAGES + SETTLE;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic              probe_q, probe_d;
  logic [4:0]        a_q, a_d;
  logic [TS_W-1:0]   ts_q, ts_d, fft_q, fft_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
  logic              q_sync, sample, mismatch, wrap;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (q_in),
    .q      (q_sync)
  );

  assign sample   = (state_q == RUN) && (phase_q == PW'(SIDX));
  // clear wins over a coincident mismatch: the sample is dropped entirely
  assign mismatch = sample && (q_sync != (parity5(a_q) ^ probe_q)) && !clear;
  assign wrap     = phase_q == PW'(HALF_PERIOD - 1);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    probe_d  = probe_q;
    a_d      = a_q;
    ts_d     = clear ? '0 : ts_q + 1'b1;
    cnt_d    = clear ? '0 : cnt_q + CNT_W'(mismatch && cnt_q != CNT_MAX);
    sticky_d = !clear && (sticky_q || mismatch);
    fft_d    = clear ? '0 : (mismatch && !sticky_q) ? ts_q : fft_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        probe_d = 1'b0;
        if (en) begin
          state_d = RUN;
          a_d     = a_in;
        end
      end
      RUN: begin
        phase_d = wrap ? '0 : phase_q + 1'b1;
        probe_d = wrap ? ~probe_q : probe_q;
        a_d     = wrap ? a_in : a_q;
        if (cnt_d == CNT_MAX) begin
          state_d = HOLD;
          phase_d = phase_q;
          probe_d = probe_q;
          a_d     = a_q;
        end else if (!en) begin
          state_d = IDLE;
          phase_d = '0;
          probe_d = 1'b0;
        end
      end
      default: begin
        if (clear) begin
          state_d = IDLE;
          phase_d = '0;
          probe_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      probe_q  <= 1'b0;
      a_q      <= '0;
      ts_q     <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      fft_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      probe_q  <= probe_d;
      a_q      <= a_d;
      ts_q     <= ts_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      fft_q    <= fft_d;
    end

  assign a_out            = a_q;
  assign probe            = probe_q;
  assign active           = state_q == RUN;
  assign sample_valid     = sample;
  assign fault_pulse      = mismatch;
  assign fault_sticky     = sticky_q;
  assign fault_count      = cnt_q;
  assign first_fault_time = fft_q;
endmodule

// File: doc/xor_fault_monitor.md
Name: xor_fault_monitor

Overview:
- Companion stage to the laser-target XOR gate. It drives the gate's toggling probe input and consumes the gate output q.
- It generates a slow square-wave probe and presents a 5-bit input pattern. It synchronises q, compares it against the expected parity(a) ^ probe once per half-period, and counts mismatches.
- It captures the time of the first fault and holds sticky status, so laser-induced faults can be located and logged.

Parameters:
- HALF_PERIOD, 64, clk cycles per probe half-period (>= SETTLE+SYNC_STAGES+2)
- SYNC_STAGES, 2, flip-flop stages on q_in (2..4)
- SETTLE, 8, extra cycles after sync before sampling
- CNT_W, 16, fault counter width
- TS_W, 32, timestamp counter width

Ports:
- clk  in  1  monitor clock, rising edge
- resetn  in  1  asynchronous active-low reset
- en  in  1  run enable, active high
- clear  in  1  synchronous clear of count/sticky/timestamp, active high
- a_in  in  5  input pattern for the gate
- q_in  in  1  gate output, asynchronous to clk
- a_out  out  5  registered pattern driven to the gate
- probe  out  1  square wave driven to the gate's clock input
- active  out  1  high while in RUN
- sample_valid  out  1  one-cycle pulse at each comparison
- fault_pulse  out  1  one-cycle pulse on a mismatch
- fault_sticky  out  1  set on first mismatch, held until clear
- fault_count  out  CNT_W  saturating mismatch count
- first_fault_time  out  TS_W  timestamp of the first mismatch

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser chain 0, timestamp counter 0.
- States:
  - IDLE: probe=0, phase counter=0. en=1 -> RUN next cycle; a_out <= a_in on entry.
  - RUN: phase counter counts 0..HALF_PERIOD-1. At wrap, probe toggles and a_out <= a_in (pattern updates only at half-period boundaries). en=0 -> IDLE next cycle; probe forced 0; count and sticky held.
  - HOLD: entered from RUN when fault_count reaches its saturation value 2^CNT_W-1. probe frozen at its current value, no sampling. Leaves only via clear (-> IDLE) or reset.
- Expected value exp = ^a_out ^ probe, taken at the sample instant. a_out and probe are both constant through the half-period.
- Sample point: phase counter == SYNC_STAGES+SETTLE, in RUN only.
  - sample_valid=1 for that cycle.
  - If q_sync != exp: fault_pulse=1 the same cycle; fault_count increments (saturating); fault_sticky <= 1 the next cycle.
  - If fault_sticky was 0, first_fault_time <= current timestamp.
- Timestamp counter: free-running from reset, increments every cycle in all states, wraps modulo 2^TS_W. Cleared by clear.
- clear:
  - Zeroes fault_count, fault_sticky, first_fault_time and the timestamp.
  - Has priority over a simultaneous mismatch; that sample is discarded and no pulse is produced.
  - Does not change state, except HOLD -> IDLE.
- en falling on the sample cycle: the sample is still evaluated, then the FSM moves to IDLE.
- Latency: a mismatch caused at q_in is reported via fault_pulse no later than HALF_PERIOD cycles after it becomes stable across a sample point.
- Glitches shorter than the window between sample points are not guaranteed to be detected. This is by design.

Decomposition:
- Package xor_mon_pkg:
  - state enum {IDLE, RUN, HOLD}
  - function parity5
  - localparam SAMPLE_IDX = SYNC_STAGES+SETTLE
- Sub-module: sync_chain (parameterised SYNC_STAGES flop chain, reset to 0), instantiated once on q_in. All other logic sits in the top block.

Test Plan:
- Loopback model q_in = ^a_out ^ probe; a_in=5'b00000; en=1 for 10 half-periods -> probe toggles every 64 cycles, 10 sample_valid pulses, fault_count=0, fault_sticky=0.
- a_in=5'b10110 with the model inverting q_in during half-period 3 only -> exactly one fault_pulse; fault_count=1; fault_sticky=1; first_fault_time equals the timestamp at that sample.
- a_in switched from 5'b00001 to 5'b00011 mid-half-period -> a_out changes only at the next probe toggle; with the loopback model no faults are reported.
- CNT_W=2 with q_in stuck at 1 and a_in=0 -> count reaches 3, FSM enters HOLD, probe frozen; clear -> count 0, state IDLE, then RUN again since en=1.
- clear asserted on the same cycle as a mismatch sample -> no fault_pulse, count 0, sticky 0.
- resetn pulsed low mid-RUN, asynchronously between clock edges -> all outputs 0 immediately; after release with en=1, RUN resumes with phase counter 0 and probe 0.
